// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the fault rule.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } lsu_size_e;

   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ACCESS   = 2'b01,
      ST_MERGE_WR = 2'b10,
      ST_RESP     = 2'b11
   } lsu_state_e;

   // True when the access must not touch memory: misaligned or illegal size.
   function automatic logic lsu_fault(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         SZ_WORD: return (addr_lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load data and merges store data
// into an existing word, with the byte order chosen by BIG_ENDIAN.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Lane numbers count from bit 0 upward; big-endian offset 0 is the top lane.
   assign byte_lane = BIG_ENDIAN ? (2'd3 - addr_lo_i) : addr_lo_i;
   assign half_lane = BIG_ENDIAN ? ~addr_lo_i[1] : addr_lo_i[1];
   assign byte_val  = rdata_i[{byte_lane, 3'b000} +: 8];
   assign half_val  = rdata_i[{half_lane, 4'b0000} +: 16];

   always_comb begin
      load_data_o = rdata_i;
      merged_o    = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_data_o = {{24{signed_i & byte_val[7]}}, byte_val};
            merged_o[{byte_lane, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_data_o = {{16{signed_i & half_val[15]}}, half_val};
            merged_o[{half_lane, 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request/response port and a
// word-wide data memory; sub-word stores use read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic        mem_write_en,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output lsu_state_e  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; the request side is ready only in IDLE, the response is held
   // stable in RESP until resp_ready.

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic [31:0] merged_q, merged_d;

   logic [31:0] load_data;
   logic [31:0] merged_word;

   lsu_lane_align #(
      .BIG_ENDIAN(BIG_ENDIAN)
   ) u_align (
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .signed_i   (signed_q),
      .rdata_i    (mem_read_data),
      .wdata_i    (wdata_q),
      .load_data_o(load_data),
      .merged_o   (merged_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         merged_q <= merged_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      signed_d     = signed_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      fault_d      = fault_q;
      merged_d     = merged_q;
      mem_write_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               size_d   = req_size;
               signed_d = req_signed;
               write_d  = req_write;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               fault_d  = lsu_fault(req_size, req_addr[1:0]);
               state_d  = fault_d ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!write_q) begin
               rdata_d = load_data;
               state_d = ST_RESP;
            end else if (size_q == SZ_WORD) begin
               mem_write_en = 1'b1;
               state_d      = ST_RESP;
            end else begin
               merged_d = merged_word;
               state_d  = ST_MERGE_WR;
            end
         end
         ST_MERGE_WR: begin
            mem_write_en = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready      = (state_q == ST_IDLE);
   assign resp_valid     = (state_q == ST_RESP);
   assign resp_rdata     = rdata_q;
   assign resp_fault     = fault_q;
   assign mem_addr       = {addr_q[31:2], 2'b00};
   assign mem_write_data = (state_q == ST_MERGE_WR) ? merged_q : wdata_q;
   assign dbg_state      = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BIG_ENDIAN, default 1: byte offset 0 maps to word bits [31:24] when 1, and to bits [7:0] when 0.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU presents an access request.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 req_signed  input  1  load sign-extends when 1 and zero-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  response is available.
REQ-012 resp_ready  input  1  CPU accepts the response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-014 resp_fault  output  1  request was misaligned or had an illegal size, and no memory access occurred.
REQ-015 mem_addr  output  32  word address to data memory; bits [1:0] always 00.
REQ-016 mem_write_en  output  1  write strobe, one cycle per write.
REQ-017 mem_write_data  output  32  full word to write.
REQ-018 mem_read_data  input  32  asynchronous read data for mem_addr.

Function
REQ-019 States: IDLE, ACCESS, MERGE_WR, RESP. Encoding is held in the package.
REQ-020 IDLE: a request is accepted on the edge where req_valid and req_ready are both high; addr, size, signed, write and wdata are registered.
REQ-021 Fault check at accept: halfword with addr[0]=1, word with addr[1:0]!=00, or size=11 -> go directly to RESP with resp_fault=1, resp_rdata=0, and no memory strobe.
REQ-022 ACCESS: mem_addr = {addr[31:2],2'b00} (mem_addr is driven to this value in every state after accept).
REQ-023 ACCESS, load: select the byte lane(s) from mem_read_data, extend to 32 bits per req_signed, register the result, then go to RESP.
REQ-024 ACCESS, word store: mem_write_en=1 with mem_write_data=wdata, then go to RESP.
REQ-025 ACCESS, byte or halfword store: capture the old word, merge wdata into the addressed lane(s), then go to MERGE_WR.
REQ-026 MERGE_WR: mem_write_en=1 with the merged word, then go to RESP.
REQ-027 RESP: resp_valid=1 with stable outputs until resp_ready=1; return to IDLE on that edge.
REQ-028 Latency from the accept edge N to resp_valid high: fault N+1; load and word store N+2; sub-word store N+3.
REQ-029 Lane selection uses addr[1:0] for bytes and addr[1] for halfwords, mapped per BIG_ENDIAN. Unaddressed lanes are preserved bit-exact on stores.
REQ-030 mem_write_en is 0 in IDLE, RESP and in ACCESS for loads and sub-word stores. At most one write occurs per request.
REQ-031 req_valid, or changes to any req_* input, outside IDLE are ignored. There is no queuing.
REQ-032 resp_ready held high in IDLE has no effect.
REQ-033 Back-to-back operation: the RESP->IDLE edge allows acceptance on the very next cycle, with no bubble beyond IDLE.

Reset
REQ-034 Reset asserted forces IDLE immediately: req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_write_en=0, mem_addr=0, mem_write_data=0.
REQ-035 Reset during MERGE_WR cancels the pending write; an in-flight request is dropped with no response.
REQ-036 After reset deassertion, the first request is accepted on the first rising edge at which req_valid is high.

Structure
REQ-037 Package lsu_pkg holds the size enum (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the SZ_ILLEGAL constant.
REQ-038 Sub-module lsu_lane_align is purely combinational: lane extract with sign/zero extension, and lane merge for stores. It is parameterised by BIG_ENDIAN.
REQ-039 The bench drives the memory side with the existing 64-word asynchronous-read, synchronous-write data memory model.

Verification
REQ-040 Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10 -> rdata 0xDEADBEEF; store response at N+2; exactly one write strobe.
REQ-041 Signed and unsigned byte loads, BIG_ENDIAN=1: memory[0x10]=0x80A1B2C3, lb from 0x10 -> 0xFFFFFF80; lbu from 0x13 -> 0x000000C3.
REQ-042 Halfword store merge: sh 0x1234 to 0x12 over 0xDEADBEEF -> memory 0xDEAD1234; lhu from 0x10 -> 0x0000DEAD; resp at N+3.
REQ-043 Faults: lw from 0x12, lh from 0x11, and size=11 -> each gives resp_fault=1 at N+1, mem_write_en never asserted, memory unchanged.
REQ-044 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready stays 0; a new request is accepted the cycle after resp_ready.
REQ-045 Reset mid-operation: assert reset during MERGE_WR of sb 0xAA to 0x10 -> no write, memory stays 0xDEADBEEF, all outputs at reset values immediately.
